// File: rtl/menu_pkg.sv
// rtl/menu_pkg.sv - shared types and constants for the OLED menu selector
//
// Purpose: FSM state encoding, RGB565 colour constants, OLED geometry and
// pixel/compare widths used by menu_if, menu_row_decode and menu_selector.
// Ports: none (package).
package menu_pkg;

   typedef enum logic [1:0] {
      INACTIVE = 2'd0,
      BROWSE   = 2'd1,
      COMMIT   = 2'd2
   } menu_state_e;

   localparam int OLED_W = 96;
   localparam int OLED_H = 64;

   localparam int X_W   = 7;   // pixel column 0..95
   localparam int Y_W   = 6;   // pixel row 0..63
   localparam int PIX_W = 16;  // RGB565
   localparam int CMP_W = 8;   // width for bound compares; holds TOP_Y + n*ITEM_H without wrap

   localparam logic [PIX_W-1:0] COL_BLACK = 16'h0000;
   localparam logic [PIX_W-1:0] COL_GREEN = 16'h07E0;
   localparam logic [PIX_W-1:0] COL_RED   = 16'hF800;
   localparam logic [PIX_W-1:0] COL_WHITE = 16'hFFFF;

endpackage

// File: rtl/menu_if.sv
// rtl/menu_if.sv - button, pixel-coordinate and selection bundle of the menu selector
//
// Purpose: groups the button pulses, the pixel coordinate request and the
// cursor/commit/pixel results exchanged with menu_selector.
// Ports (via modports):
//   master - drives btn_up, btn_down, btn_sel, X, Y; receives cursor,
//            sel_valid, sel_item, oled_data.
//   slave  - the menu controller side (directions reversed).
interface menu_if
   import menu_pkg::*;
#(
   parameter int NUM_ITEMS = 4
) ();

   localparam int CW = $clog2(NUM_ITEMS);

   logic             btn_up;
   logic             btn_down;
   logic             btn_sel;
   logic [X_W-1:0]   X;
   logic [Y_W-1:0]   Y;
   logic [CW-1:0]    cursor;
   logic             sel_valid;
   logic [CW-1:0]    sel_item;
   logic [PIX_W-1:0] oled_data;

   modport master (
      output btn_up, btn_down, btn_sel, X, Y,
      input  cursor, sel_valid, sel_item, oled_data
   );

   modport slave (
      input  btn_up, btn_down, btn_sel, X, Y,
      output cursor, sel_valid, sel_item, oled_data
   );

endinterface

// File: rtl/menu_row_decode.sv
// rtl/menu_row_decode.sv - combinational pixel row to menu item band decoder
//
// Purpose: maps a pixel row onto the list of equal-height item bands starting
// at TOP_Y, using one constant-bound compare per band (no divider).
// Ports:
//   y_i       in  Y_W  pixel row
//   in_band_o out 1    y_i lies inside one of the NUM_ITEMS bands
//   row_o     out RW   index of that band (0 when outside)
//   is_edge_o out 1    y_i is the first pixel row of that band
module menu_row_decode
   import menu_pkg::*;
#(
   parameter  int NUM_ITEMS = 4,
   parameter  int TOP_Y     = 4,
   parameter  int ITEM_H    = 14,
   localparam int RW        = $clog2(NUM_ITEMS)
) (
   input  logic [Y_W-1:0] y_i,
   output logic           in_band_o,
   output logic [RW-1:0]  row_o,
   output logic           is_edge_o
);

   logic [CMP_W-1:0] y_w;

   assign y_w = CMP_W'(y_i);

   // Bands are disjoint, so at most one iteration matches.
   always_comb begin
      in_band_o = 1'b0;
      row_o     = '0;
      is_edge_o = 1'b0;
      for (int r = 0; r < NUM_ITEMS; r++) begin
         if ((y_w >= CMP_W'(TOP_Y + r * ITEM_H)) &&
             (y_w <  CMP_W'(TOP_Y + (r + 1) * ITEM_H))) begin
            in_band_o = 1'b1;
            row_o     = RW'(r);
            is_edge_o = (y_w == CMP_W'(TOP_Y + r * ITEM_H));
         end
      end
   end

endmodule

// File: rtl/menu_selector.sv
// rtl/menu_selector.sv - menu cursor FSM with registered RGB565 menu rendering
//
// Purpose: tracks a cursor over NUM_ITEMS entries from up/down pulses,
// commits the current entry on a select pulse and renders the item bars
// (cursor row highlighted) for the 96x64 OLED with one cycle of latency.
// Ports:
//   clk    in  1  system clock
//   reset  in  1  synchronous active-high reset
//   state  in  4  top-level state; menu is active when equal to MENU_STATE
//   bus    menu_if.slave: btn_up/btn_down/btn_sel pulses and X/Y in;
//          cursor, sel_valid, sel_item, oled_data out
module menu_selector
   import menu_pkg::*;
#(
   parameter int               NUM_ITEMS  = 4,
   parameter int               WRAP       = 0,
   parameter int               RETAIN     = 0,
   parameter logic [3:0]       MENU_STATE = 4'b0000,
   parameter int               TOP_Y      = 4,
   parameter int               ITEM_H     = 14,
   parameter int               MARGIN_X   = 8,
   parameter logic [PIX_W-1:0] BG_COL     = COL_BLACK,
   parameter logic [PIX_W-1:0] ITEM_COL   = COL_GREEN,
   parameter logic [PIX_W-1:0] HL_COL     = COL_RED,
   parameter logic [PIX_W-1:0] EDGE_COL   = COL_WHITE
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] state,
   menu_if.slave      bus
);

   localparam int            CW   = $clog2(NUM_ITEMS);
   localparam logic [CW-1:0] LAST = CW'(NUM_ITEMS - 1);

   if ((NUM_ITEMS < 2) || (NUM_ITEMS > 16)) begin : g_bad_items
      $error("menu_selector: NUM_ITEMS must be within 2..16");
   end
   if (TOP_Y + NUM_ITEMS * ITEM_H > OLED_H) begin : g_bad_geom
      $error("menu_selector: item bands run past the bottom of the screen");
   end

   menu_state_e      fsm_q, fsm_d;
   logic [CW-1:0]    cursor_q, cursor_d;
   logic [CW-1:0]    sel_item_q, sel_item_d;
   logic [PIX_W-1:0] pix_q, pix_d;
   logic             menu_active;

   assign menu_active = (state == MENU_STATE);

   // ---------------------------------------------------------------- FSM
   always_comb begin
      fsm_d      = fsm_q;
      cursor_d   = cursor_q;
      sel_item_d = sel_item_q;
      unique case (fsm_q)
         INACTIVE: begin
            if (menu_active) begin
               fsm_d = BROWSE;
               if (RETAIN == 0) cursor_d = '0;
            end
         end
         BROWSE: begin
            if (!menu_active) begin
               fsm_d = INACTIVE;
            end else if (bus.btn_sel) begin
               fsm_d      = COMMIT;
               sel_item_d = cursor_q;
            end else if (bus.btn_up && !bus.btn_down) begin
               if (cursor_q == '0) cursor_d = (WRAP != 0) ? LAST : '0;
               else                cursor_d = cursor_q - CW'(1);
            end else if (bus.btn_down && !bus.btn_up) begin
               // Compare against the last legal item, not the all-ones value.
               if (cursor_q == LAST) cursor_d = (WRAP != 0) ? '0 : LAST;
               else                  cursor_d = cursor_q + CW'(1);
            end
         end
         COMMIT: begin
            fsm_d = menu_active ? BROWSE : INACTIVE;
         end
         default: begin
            fsm_d = INACTIVE;
         end
      endcase
   end

   // ------------------------------------------------------ pixel pipeline
   logic             in_band;
   logic [CW-1:0]    row;
   logic             is_edge;
   logic [CMP_W-1:0] x_w;
   logic             in_x;

   menu_row_decode #(
      .NUM_ITEMS (NUM_ITEMS),
      .TOP_Y     (TOP_Y),
      .ITEM_H    (ITEM_H)
   ) u_row_decode (
      .y_i       (bus.Y),
      .in_band_o (in_band),
      .row_o     (row),
      .is_edge_o (is_edge)
   );

   assign x_w  = CMP_W'(bus.X);
   assign in_x = (x_w >= CMP_W'(MARGIN_X)) && (x_w < CMP_W'(OLED_W - MARGIN_X));

   // Highlight uses the cursor currently held, i.e. the value registered
   // alongside this X,Y sample, not the one being computed this cycle.
   always_comb begin
      pix_d = BG_COL;
      if (in_x && in_band) begin
         if (is_edge)               pix_d = EDGE_COL;
         else if (row == cursor_q)  pix_d = HL_COL;
         else                       pix_d = ITEM_COL;
      end
   end

   // ----------------------------------------------------------- registers
   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q      <= INACTIVE;
         cursor_q   <= '0;
         sel_item_q <= '0;
         pix_q      <= BG_COL;
      end else begin
         fsm_q      <= fsm_d;
         cursor_q   <= cursor_d;
         sel_item_q <= sel_item_d;
         pix_q      <= pix_d;
      end
   end

   assign bus.cursor    = cursor_q;
   assign bus.sel_valid = (fsm_q == COMMIT);
   assign bus.sel_item  = sel_item_q;
   assign bus.oled_data = pix_q;

endmodule

// File: tb/tb_menu_selector.sv
// tb/tb_menu_selector.sv - self-checking bench for menu_selector
//
// Three instances: u0 (4 items, saturate, clear on entry), u1 (5 items,
// wrap, ITEM_H 12), u2 (4 items, saturate, retain cursor).
module tb_menu_selector;

   typedef struct {
      int         d;     // instance driven and checked
      bit         rst;
      logic [3:0] st;
      logic       u;
      logic       dn;
      logic       s;
      logic [6:0] x;
      logic [5:0] y;
      logic [3:0] cur;   // expected after the clock edge
      logic       sv;
      logic [3:0] si;
      logic [15:0] px;
      bit         cp;    // compare oled_data
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [3:0]  st[3];
   logic        up[3], dn[3], sl[3];
   logic [6:0]  xx[3];
   logic [5:0]  yy[3];
   logic [3:0]  cur[3], si[3];
   logic        sv[3];
   logic [15:0] pix[3];

   int   n_cmp = 0;
   int   n_bad = 0;
   int   vec_no = 0;
   vec_t tbl[$];
   vec_t exp_q[$];

   menu_if #(.NUM_ITEMS(4)) bus0 ();
   menu_if #(.NUM_ITEMS(5)) bus1 ();
   menu_if #(.NUM_ITEMS(4)) bus2 ();

   assign bus0.btn_up = up[0]; assign bus0.btn_down = dn[0]; assign bus0.btn_sel = sl[0];
   assign bus0.X = xx[0];      assign bus0.Y = yy[0];
   assign bus1.btn_up = up[1]; assign bus1.btn_down = dn[1]; assign bus1.btn_sel = sl[1];
   assign bus1.X = xx[1];      assign bus1.Y = yy[1];
   assign bus2.btn_up = up[2]; assign bus2.btn_down = dn[2]; assign bus2.btn_sel = sl[2];
   assign bus2.X = xx[2];      assign bus2.Y = yy[2];

   assign cur[0] = 4'(bus0.cursor); assign si[0] = 4'(bus0.sel_item);
   assign sv[0]  = bus0.sel_valid;  assign pix[0] = bus0.oled_data;
   assign cur[1] = 4'(bus1.cursor); assign si[1] = 4'(bus1.sel_item);
   assign sv[1]  = bus1.sel_valid;  assign pix[1] = bus1.oled_data;
   assign cur[2] = 4'(bus2.cursor); assign si[2] = 4'(bus2.sel_item);
   assign sv[2]  = bus2.sel_valid;  assign pix[2] = bus2.oled_data;

   menu_selector #(.NUM_ITEMS(4), .WRAP(0), .RETAIN(0)) u0 (
      .clk(clk), .reset(reset), .state(st[0]), .bus(bus0));
   menu_selector #(.NUM_ITEMS(5), .WRAP(1), .RETAIN(0), .ITEM_H(12)) u1 (
      .clk(clk), .reset(reset), .state(st[1]), .bus(bus1));
   menu_selector #(.NUM_ITEMS(4), .WRAP(0), .RETAIN(1)) u2 (
      .clk(clk), .reset(reset), .state(st[2]), .bus(bus2));

   function automatic vec_t mk(int d, bit r, int s_, bit u_, bit dn_, bit sel_,
                               int x_, int y_, int cur_, bit sv_, int si_,
                               logic [15:0] px_, bit cp_);
      vec_t v;
      v.d = d; v.rst = r; v.st = 4'(s_); v.u = u_; v.dn = dn_; v.s = sel_;
      v.x = 7'(x_); v.y = 6'(y_); v.cur = 4'(cur_); v.sv = sv_; v.si = 4'(si_);
      v.px = px_; v.cp = cp_;
      return v;
   endfunction

   task automatic chk(input string nm, input int id, input int k,
                      input logic [15:0] act, input logic [15:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s vec%0d dut%0d: got %h required %h", nm, id, k, act, req);
      end
   endtask

   task automatic step(input vec_t v);
      vec_t e;
      @(negedge clk);
      reset = v.rst;
      for (int k = 0; k < 3; k++) begin
         up[k] = 1'b0; dn[k] = 1'b0; sl[k] = 1'b0;
      end
      st[v.d] = v.st; up[v.d] = v.u; dn[v.d] = v.dn; sl[v.d] = v.s;
      xx[v.d] = v.x;  yy[v.d] = v.y;
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("cursor",    vec_no, e.d, 16'(cur[e.d]), 16'(e.cur));
      chk("sel_valid", vec_no, e.d, 16'(sv[e.d]),  16'(e.sv));
      chk("sel_item",  vec_no, e.d, 16'(si[e.d]),  16'(e.si));
      if (e.cp) chk("oled_data", vec_no, e.d, pix[e.d], e.px);
      vec_no++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         st[k] = 4'd0; up[k] = 1'b0; dn[k] = 1'b0; sl[k] = 1'b0;
         xx[k] = 7'd0; yy[k] = 6'd0;
      end

      // columns: dut rst state | up down sel | X Y | cursor sel_valid sel_item | oled check
      tbl.push_back(mk(0,0,0, 0,1,0,  0, 0, 0,0,0, 16'h0000,1)); // entry: button ignored
      tbl.push_back(mk(0,0,0, 0,1,0,  0, 0, 1,0,0, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,1,0,  0, 0, 2,0,0, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,1,0,  0, 0, 3,0,0, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,1,0,  0, 0, 3,0,0, 16'h0000,0)); // saturate top
      tbl.push_back(mk(0,0,0, 1,0,0,  0, 0, 2,0,0, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 1,0,0,  0, 0, 1,0,0, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 1,0,0,  0, 0, 0,0,0, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 1,0,0,  0, 0, 0,0,0, 16'h0000,0)); // saturate bottom
      tbl.push_back(mk(0,0,0, 1,0,0,  0, 0, 0,0,0, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,1,0,  0, 0, 1,0,0, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 1,1,0,  0, 0, 1,0,0, 16'h0000,0)); // both: no move
      tbl.push_back(mk(0,0,0, 0,0,0, 20,18, 1,0,0, 16'hFFFF,1)); // edge row 1
      tbl.push_back(mk(0,0,0, 0,0,0, 20,25, 1,0,0, 16'hF800,1)); // highlighted row 1
      tbl.push_back(mk(0,0,0, 0,0,0, 20,10, 1,0,0, 16'h07E0,1)); // row 0
      tbl.push_back(mk(0,0,0, 0,0,0,  3,25, 1,0,0, 16'h0000,1)); // left margin
      tbl.push_back(mk(0,0,0, 0,0,0, 20,62, 1,0,0, 16'h0000,1)); // below last band
      tbl.push_back(mk(0,0,0, 0,0,0, 87,59, 1,0,0, 16'h07E0,1)); // last column/row inside
      tbl.push_back(mk(0,0,0, 0,0,0, 88,25, 1,0,0, 16'h0000,1)); // right margin
      tbl.push_back(mk(0,0,0, 0,0,0,  8, 4, 1,0,0, 16'hFFFF,1)); // first column, TOP_Y edge
      tbl.push_back(mk(0,0,0, 0,0,0, 20, 3, 1,0,0, 16'h0000,1)); // above first band
      tbl.push_back(mk(0,0,0, 0,0,0, 20,31, 1,0,0, 16'hF800,1));
      tbl.push_back(mk(0,0,0, 0,0,0, 20,32, 1,0,0, 16'hFFFF,1));
      tbl.push_back(mk(0,0,0, 0,1,0,  0, 0, 2,0,0, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,1,1,  0, 0, 2,1,2, 16'h0000,0)); // sel beats down
      tbl.push_back(mk(0,0,0, 0,1,0,  0, 0, 2,0,2, 16'h0000,0)); // ignored in COMMIT
      tbl.push_back(mk(0,0,0, 0,0,1,  0, 0, 2,1,2, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,0,1,  0, 0, 2,0,2, 16'h0000,0)); // back-to-back sel
      tbl.push_back(mk(0,0,0, 0,0,1,  0, 0, 2,1,2, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,0,0,  0, 0, 2,0,2, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,1,0,  0, 0, 3,0,2, 16'h0000,0));
      tbl.push_back(mk(0,0,1, 0,1,0,  0, 0, 3,0,2, 16'h0000,0)); // leave: pending ignored
      tbl.push_back(mk(0,0,1, 0,0,0,  0, 0, 3,0,2, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,0,0,  0, 0, 0,0,2, 16'h0000,0)); // re-entry clears
      tbl.push_back(mk(0,0,0, 0,1,0, 20,25, 1,0,2, 16'h07E0,1)); // old cursor for pixel
      tbl.push_back(mk(0,0,0, 0,0,0, 20,25, 1,0,2, 16'hF800,1));
      tbl.push_back(mk(0,0,0, 0,0,1,  0, 0, 1,1,1, 16'h0000,0));
      tbl.push_back(mk(0,0,1, 0,0,0,  0, 0, 1,0,1, 16'h0000,0)); // COMMIT -> INACTIVE
      tbl.push_back(mk(0,0,1, 0,1,0,  0, 0, 1,0,1, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,0,0,  0, 0, 0,0,1, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,1,0,  0, 0, 1,0,1, 16'h0000,0));
      tbl.push_back(mk(0,0,0, 0,0,1,  0, 0, 1,1,1, 16'h0000,0));
      tbl.push_back(mk(0,1,0, 0,0,0, 20,25, 0,0,0, 16'h0000,1)); // reset mid-COMMIT

      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("reset_cursor",    -1, k, 16'(cur[k]), 16'h0000);
         chk("reset_sel_valid", -1, k, 16'(sv[k]),  16'h0000);
         chk("reset_sel_item",  -1, k, 16'(si[k]),  16'h0000);
         chk("reset_oled_data", -1, k, pix[k],      16'h0000);
      end

      foreach (tbl[i]) step(tbl[i]);

      // u1: five items with wrap; bands of 12 rows from Y=4
      step(mk(1,0,0, 0,0,0,  0, 0, 0,0,0, 16'h0000,0));
      step(mk(1,0,0, 1,0,0,  0, 0, 4,0,0, 16'h0000,0)); // wrap 0 -> 4
      step(mk(1,0,0, 0,1,0,  0, 0, 0,0,0, 16'h0000,0)); // wrap 4 -> 0
      step(mk(1,0,0, 0,1,0,  0, 0, 1,0,0, 16'h0000,0));
      step(mk(1,0,0, 1,0,0,  0, 0, 0,0,0, 16'h0000,0));
      step(mk(1,0,0, 1,0,0,  0, 0, 4,0,0, 16'h0000,0));
      step(mk(1,0,0, 1,0,0,  0, 0, 3,0,0, 16'h0000,0));
      step(mk(1,0,0, 0,1,0,  0, 0, 4,0,0, 16'h0000,0));
      step(mk(1,0,0, 0,1,0, 20,63, 0,0,0, 16'hF800,1)); // row 4 highlighted by old cursor
      step(mk(1,0,0, 0,0,0, 20,52, 0,0,0, 16'hFFFF,1));
      step(mk(1,0,0, 0,0,0, 20,63, 0,0,0, 16'h07E0,1));
      step(mk(1,0,0, 1,0,0,  0, 0, 4,0,0, 16'h0000,0));
      step(mk(1,0,0, 0,0,1,  0, 0, 4,1,4, 16'h0000,0));
      step(mk(1,0,0, 0,0,0,  0, 0, 4,0,4, 16'h0000,0));

      // u2: cursor retained across leaving the menu
      step(mk(2,0,0, 0,1,0,  0, 0, 1,0,0, 16'h0000,0));
      step(mk(2,0,0, 0,1,0,  0, 0, 2,0,0, 16'h0000,0));
      step(mk(2,0,0, 0,1,0,  0, 0, 3,0,0, 16'h0000,0));
      step(mk(2,0,1, 0,0,0,  0, 0, 3,0,0, 16'h0000,0));
      step(mk(2,0,1, 1,0,0,  0, 0, 3,0,0, 16'h0000,0));
      step(mk(2,0,0, 0,0,0,  0, 0, 3,0,0, 16'h0000,0)); // re-entry keeps 3
      step(mk(2,0,0, 1,0,0,  0, 0, 2,0,0, 16'h0000,0));
      step(mk(2,0,0, 0,0,1,  0, 0, 2,1,2, 16'h0000,0));
      step(mk(2,0,0, 0,0,0,  0, 0, 2,0,2, 16'h0000,0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
